// File: rtl/nanorv32_useq_pkg.sv
// Shared constants for the nanorv32 micro-sequencer: state encoding,
// default widths and the well-known entry indices.
package nanorv32_parameter;

  localparam int UROM_ADDR_W_DEF = 5;
  localparam int DATA_W_DEF      = 32;
  localparam int NUM_ENTRY_DEF   = 4;

  localparam int RESET     = 0;
  localparam int IRQ_ENTRY = 1;
  localparam int IRQ_EXIT  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } useq_state_e;

endpackage

// File: rtl/nanorv32_useq_rom.sv
// Combinational micro-ROM: each word is {LAST, payload}. The micro_rom markers
// delimit the ROM image; keep them intact.
module nanorv32_useq_rom
  import nanorv32_parameter::*;
#(
  parameter int UROM_ADDR_W = UROM_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic [UROM_ADDR_W-1:0] addr,
  output logic [DATA_W:0]        word
);

  logic        last;
  logic [31:0] payload;

  always_comb begin
    case (int'(addr))
      // micro_rom begin
      0:       {last, payload} = {1'b0, 32'h0000_0093};
      1:       {last, payload} = {1'b0, 32'h0000_0113};
      2:       {last, payload} = {1'b1, 32'h3000_1073};
      8:       {last, payload} = {1'b0, 32'h3410_2573};
      9:       {last, payload} = {1'b0, 32'h3420_2673};
      10:      {last, payload} = {1'b0, 32'h00a1_2023};
      11:      {last, payload} = {1'b1, 32'h00c1_2223};
      16:      {last, payload} = {1'b0, 32'h3415_1073};
      17:      {last, payload} = {1'b1, 32'h3020_0073};
      24:      {last, payload} = {1'b0, 32'h0010_0013};
      25:      {last, payload} = {1'b0, 32'h0020_0013};
      26:      {last, payload} = {1'b0, 32'h0030_0013};
      27:      {last, payload} = {1'b0, 32'h0040_0013};
      28:      {last, payload} = {1'b0, 32'h0050_0013};
      29:      {last, payload} = {1'b0, 32'h0060_0013};
      30:      {last, payload} = {1'b0, 32'h0070_0013};
      31:      {last, payload} = {1'b0, 32'h0080_0013};
      // micro_rom end
      // Unused slots hold a terminating NOP so a stray entry stops at once.
      default: {last, payload} = {1'b1, 32'h0000_0013};
    endcase
    word = {last, DATA_W'(payload)};
  end

endmodule

// File: rtl/nanorv32_useq.sv
// Micro-sequencer: on start, streams micro-ROM words from an entry point to the
// core over a valid/ready handshake until a LAST word, the ROM end, or abort.
module nanorv32_useq
  import nanorv32_parameter::*;
#(
  parameter int UROM_ADDR_W = UROM_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_ENTRY   = NUM_ENTRY_DEF,
  parameter logic [NUM_ENTRY*UROM_ADDR_W-1:0] ENTRY_BASE = {5'd24, 5'd16, 5'd8, 5'd0},
  localparam int ENTRY_W    = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  input  logic [ENTRY_W-1:0]     start_entry,
  output logic                   start_ready,
  input  logic                   abort,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr_data,
  input  logic                   instr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [UROM_ADDR_W:0]   issued_cnt
);

  useq_state_e            state_q, state_d;
  logic [UROM_ADDR_W-1:0] pc_q, pc_d;
  logic [UROM_ADDR_W:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [DATA_W:0]        rom_word;
  logic                   word_last;
  logic                   handshake;
  logic                   entry_ok;
  logic [UROM_ADDR_W-1:0] entry_pc;

  nanorv32_useq_rom #(
    .UROM_ADDR_W (UROM_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_rom (
    .addr (pc_q),
    .word (rom_word)
  );

  assign word_last   = rom_word[DATA_W];
  assign instr_data  = rom_word[DATA_W-1:0];
  // Valid is a pure function of the state flop, never of instr_ready.
  assign instr_valid = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN);
  assign start_ready = (state_q == ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign issued_cnt  = cnt_q;
  assign handshake   = instr_valid & instr_ready;

  // Entry lookup by loop so an out-of-range index simply yields entry_ok=0.
  always_comb begin
    entry_ok = 1'b0;
    entry_pc = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (int'(start_entry) == i) begin
        entry_ok = 1'b1;
        entry_pc = ENTRY_BASE[i*UROM_ADDR_W +: UROM_ADDR_W];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          if (entry_ok) begin
            state_d = ST_RUN;
            pc_d    = entry_pc;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (handshake) cnt_d = cnt_q + 1'b1;
        // Abort outranks a concurrent LAST handshake: the word counts, done does not.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          if (word_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (pc_q == '1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_useq.sv
// Self-checking bench for nanorv32_useq: randomized handshakes against a
// sequence-level model that walks the ROM image from each entry point.
module tb_nanorv32_useq;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-configuration DUT (4 entries)
  logic          start_valid, abort, instr_ready;
  logic [1:0]    start_entry;
  logic          start_ready, instr_valid, busy, done, err;
  logic [DW-1:0] instr_data;
  logic [AW:0]   issued_cnt;

  // Three-entry DUT so that index 3 is out of range
  logic          start_valid_b, abort_b, instr_ready_b;
  logic [1:0]    start_entry_b;
  logic          start_ready_b, instr_valid_b, busy_b, done_b, err_b;
  logic [DW-1:0] instr_data_b;
  logic [AW:0]   issued_cnt_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int base_tab[4] = '{0, 8, 16, 24};
  int exp_q[$];
  bit exp_runaway;

  nanorv32_useq dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_entry (start_entry),
    .start_ready (start_ready),
    .abort       (abort),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .issued_cnt  (issued_cnt)
  );

  nanorv32_useq #(
    .NUM_ENTRY  (3),
    .ENTRY_BASE ({5'd16, 5'd8, 5'd0})
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid_b),
    .start_entry (start_entry_b),
    .start_ready (start_ready_b),
    .abort       (abort_b),
    .instr_valid (instr_valid_b),
    .instr_data  (instr_data_b),
    .instr_ready (instr_ready_b),
    .busy        (busy_b),
    .done        (done_b),
    .err         (err_b),
    .issued_cnt  (issued_cnt_b)
  );

  // Expected micro-ROM image: {LAST, payload}
  function automatic logic [DW:0] ref_rom(input int a);
    case (a)
      0:  return {1'b0, 32'h0000_0093};
      1:  return {1'b0, 32'h0000_0113};
      2:  return {1'b1, 32'h3000_1073};
      8:  return {1'b0, 32'h3410_2573};
      9:  return {1'b0, 32'h3420_2673};
      10: return {1'b0, 32'h00a1_2023};
      11: return {1'b1, 32'h00c1_2223};
      16: return {1'b0, 32'h3415_1073};
      17: return {1'b1, 32'h3020_0073};
      24: return {1'b0, 32'h0010_0013};
      25: return {1'b0, 32'h0020_0013};
      26: return {1'b0, 32'h0030_0013};
      27: return {1'b0, 32'h0040_0013};
      28: return {1'b0, 32'h0050_0013};
      29: return {1'b0, 32'h0060_0013};
      30: return {1'b0, 32'h0070_0013};
      31: return {1'b0, 32'h0080_0013};
      default: return {1'b1, 32'h0000_0013};
    endcase
  endfunction

  // Address list a sequence visits: from the entry base up to LAST or the ROM end.
  task automatic build_expected(input int entry);
    int a;
    logic [DW:0] w;
    a = base_tab[entry];
    exp_q.delete();
    exp_runaway = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(a);
      w = ref_rom(a);
      if (w[DW]) break;
      if (a == (1 << AW) - 1) begin
        exp_runaway = 1'b1;
        break;
      end
      a++;
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    obs = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL reset_ctrl got %b expected %b", obs, 5'b00100);
    else pass_cnt++;
    total_cnt++;
    if (issued_cnt !== '0) $display("FAIL reset_cnt got %0d expected 0", issued_cnt);
    else pass_cnt++;
    obs = {instr_valid_b, busy_b, start_ready_b, done_b, err_b};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL reset_ctrl_b got %b expected %b", obs, 5'b00100);
    else pass_cnt++;
  endtask

  // One sequence on the default DUT. pat supplies the first pat_len ready values
  // (bit 0 first); afterwards ready is random or held high. abort_hs>0 aborts on
  // that handshake; abort_cyc>=0 aborts on that RUN cycle whatever ready is.
  task automatic run_seq(input string name, input int entry, input logic [15:0] pat,
                         input int pat_len, input bit rand_ready, input int abort_hs,
                         input int abort_cyc);
    int idx, cnt, cyc;
    bit ended, aborted, r, ab;
    logic [4:0] obs, expc;
    logic [DW:0] w;
    idx = 0; cnt = 0; cyc = 0; ended = 0; aborted = 0;
    build_expected(entry);

    @(posedge clk); #1;
    start_valid = 1'b1;
    start_entry = entry[1:0];
    abort       = 1'($urandom_range(0, 1));
    instr_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    obs = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL %s idle_ctrl got %b expected %b", name, obs, 5'b00100);
    else pass_cnt++;

    @(posedge clk); #1;
    start_valid = 1'b0;
    while (!ended) begin
      r  = (cyc < pat_len) ? pat[cyc] : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      ab = (abort_hs > 0 && r && cnt + 1 == abort_hs) || (cyc == abort_cyc);
      instr_ready = r;
      abort       = ab;
      start_valid = 1'($urandom_range(0, 1));
      start_entry = 2'($urandom_range(0, 3));
      @(negedge clk);
      obs = {instr_valid, busy, start_ready, done, err};
      total_cnt++;
      if (obs !== 5'b11000) $display("FAIL %s run_ctrl cyc %0d got %b expected %b", name, cyc, obs, 5'b11000);
      else pass_cnt++;
      w = ref_rom(exp_q[idx]);
      total_cnt++;
      if (instr_data !== w[DW-1:0])
        $display("FAIL %s data cyc %0d got %h expected %h (addr %0d)", name, cyc, instr_data, w[DW-1:0], exp_q[idx]);
      else pass_cnt++;
      total_cnt++;
      if (issued_cnt !== (AW+1)'(cnt)) $display("FAIL %s run_cnt cyc %0d got %0d expected %0d", name, cyc, issued_cnt, cnt);
      else pass_cnt++;

      if (r) cnt++;
      if (ab) begin
        ended = 1; aborted = 1;
      end else if (r) begin
        idx++;
        if (idx == exp_q.size()) ended = 1;
      end
      cyc++;
      if (!ended && cyc > 300) begin
        total_cnt++;
        $display("FAIL %s timeout after %0d cycles", name, cyc);
        ended = 1;
      end
      @(posedge clk); #1;
    end

    instr_ready = 1'b0;
    abort       = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    expc = {3'b001, !aborted, !aborted && exp_runaway};
    obs  = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== expc) $display("FAIL %s end_ctrl got %b expected %b", name, obs, expc);
    else pass_cnt++;
    total_cnt++;
    if (issued_cnt !== (AW+1)'(cnt)) $display("FAIL %s end_cnt got %0d expected %0d", name, issued_cnt, cnt);
    else pass_cnt++;

    @(posedge clk); #1;
    @(negedge clk);
    obs = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL %s pulse_clear got %b expected %b", name, obs, 5'b00100);
    else pass_cnt++;
    total_cnt++;
    if (issued_cnt !== (AW+1)'(cnt)) $display("FAIL %s held_cnt got %0d expected %0d", name, issued_cnt, cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_seq();
    run_seq("reset_seq", 0, 16'h0, 0, 1'b0, 0, -1);
  endtask

  task automatic test_backpressure();
    run_seq("backpressure", 1, 16'b11_1001, 6, 1'b0, 0, -1);
  endtask

  task automatic test_abort();
    run_seq("abort", 1, 16'h0, 0, 1'b0, 2, -1);
  endtask

  task automatic test_runaway();
    run_seq("runaway", 3, 16'h0, 0, 1'b0, 0, -1);
  endtask

  task automatic test_abort_last();
    run_seq("abort_last", 2, 16'h0, 0, 1'b0, 2, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int e, ahs, acyc;
      e    = $urandom_range(0, 3);
      ahs  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      acyc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      run_seq("random", e, 16'h0, 0, 1'b1, ahs, acyc);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] obs;
    logic [DW:0] w;
    @(posedge clk); #1;
    start_valid = 1'b1; start_entry = 2'd1; instr_ready = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    w = ref_rom(10);
    total_cnt++;
    if (issued_cnt !== 6'd2 || instr_data !== w[DW-1:0])
      $display("FAIL mid_reset pre got cnt %0d data %h expected cnt 2 data %h", issued_cnt, instr_data, w[DW-1:0]);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    obs = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== 5'b00100 || issued_cnt !== '0)
      $display("FAIL mid_reset post got ctrl %b cnt %0d expected ctrl 00100 cnt 0", obs, issued_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    obs = {instr_valid, busy, start_ready, done, err};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL mid_reset no_done got %b expected %b", obs, 5'b00100);
    else pass_cnt++;
  endtask

  task automatic test_bad_entry();
    logic [4:0] obs;
    logic [DW:0] w;
    @(posedge clk); #1;
    start_valid_b = 1'b1; start_entry_b = 2'd3; instr_ready_b = 1'b1;
    @(posedge clk); #1;
    start_valid_b = 1'b0;
    @(negedge clk);
    obs = {instr_valid_b, busy_b, start_ready_b, done_b, err_b};
    total_cnt++;
    if (obs !== 5'b00101 || issued_cnt_b !== '0)
      $display("FAIL bad_entry err got ctrl %b cnt %0d expected ctrl 00101 cnt 0", obs, issued_cnt_b);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    obs = {instr_valid_b, busy_b, start_ready_b, done_b, err_b};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL bad_entry after got %b expected %b", obs, 5'b00100);
    else pass_cnt++;

    // A legal entry on the same instance still works and uses its own base table.
    @(posedge clk); #1;
    start_valid_b = 1'b1; start_entry_b = 2'd2; instr_ready_b = 1'b0;
    @(posedge clk); #1;
    start_valid_b = 1'b0;
    @(negedge clk);
    w = ref_rom(16);
    total_cnt++;
    if (instr_valid_b !== 1'b1 || instr_data_b !== w[DW-1:0])
      $display("FAIL bad_entry good_start got valid %b data %h expected valid 1 data %h", instr_valid_b, instr_data_b, w[DW-1:0]);
    else pass_cnt++;
    @(posedge clk); #1;
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    @(negedge clk);
    obs = {instr_valid_b, busy_b, start_ready_b, done_b, err_b};
    total_cnt++;
    if (obs !== 5'b00100) $display("FAIL bad_entry abort got %b expected %b", obs, 5'b00100);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0; start_entry = '0; abort = 1'b0; instr_ready = 1'b0;
    start_valid_b = 1'b0; start_entry_b = '0; abort_b = 1'b0; instr_ready_b = 1'b0;
    test_reset();
    test_reset_seq();
    test_backpressure();
    test_abort();
    test_runaway();
    test_abort_last();
    test_random();
    test_mid_reset();
    test_bad_entry();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nanorv32_useq.md
NANORV32_USEQ -- requirements
Module: nanorv32_useq

Interface
REQ-001 Parameter UROM_ADDR_W, default 5, micro-ROM address width (depth = 2**UROM_ADDR_W words).
REQ-002 Parameter DATA_W, default 32, issued instruction width.
REQ-003 Parameter NUM_ENTRY, default 4, number of sequence entry points (0 reset, 1 irq entry, 2 irq exit, 3 spare).
REQ-004 Parameter ENTRY_BASE, default {5'd24,5'd16,5'd8,5'd0}, packed NUM_ENTRY*UROM_ADDR_W start addresses, entry 0 in LSBs.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start_valid  input  1  request to run a sequence.
REQ-008 start_entry  input  clog2(NUM_ENTRY)  entry index of the request.
REQ-009 start_ready  output  1  high exactly when state is IDLE.
REQ-010 abort  input  1  terminate the running sequence.
REQ-011 instr_valid  output  1  instruction word offered to the core.
REQ-012 instr_data  output  DATA_W  current micro-ROM word, payload bits only.
REQ-013 instr_ready  input  1  core accepts instr_data.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse after a sequence terminates normally.
REQ-016 err  output  1  one-cycle pulse on bad entry or missing last flag.
REQ-017 issued_cnt  output  UROM_ADDR_W+1  words accepted in current or last sequence.

Function
REQ-018 ROM word width DATA_W+1; bit DATA_W is the LAST flag, bits DATA_W-1:0 are the payload.
REQ-019 States IDLE and RUN only.
REQ-020 IDLE: start_valid=1 with start_entry<NUM_ENTRY -> pc<=ENTRY_BASE[start_entry], issued_cnt<=0, state<=RUN.
REQ-021 IDLE: start_valid=1 with start_entry>=NUM_ENTRY -> stay IDLE, err pulses next cycle, pc and issued_cnt unchanged.
REQ-022 RUN: instr_valid=1; instr_data=ROM[pc] payload; pc changes only on handshake, so instr_data is stable while valid and not ready.
REQ-023 instr_valid shall not depend combinationally on instr_ready.
REQ-024 Handshake (instr_valid and instr_ready) with LAST=0 and pc<2**UROM_ADDR_W-1 -> pc<=pc+1, issued_cnt+1.
REQ-025 Handshake with LAST=1 -> state<=IDLE, issued_cnt+1, done pulses next cycle.
REQ-026 Handshake at pc=2**UROM_ADDR_W-1 with LAST=0 -> no wrap; state<=IDLE, done and err both pulse next cycle.
REQ-027 abort=1 in RUN -> state<=IDLE next cycle regardless of instr_ready; a word handshaken that cycle counts in issued_cnt; no done.
REQ-028 abort in IDLE is ignored; start_valid in RUN is ignored (start_ready=0).
REQ-029 Abort and LAST handshake in the same cycle -> abort wins, no done.
REQ-030 First instr_valid one cycle after the accepted start; minimum sequence of n words takes n+1 cycles with instr_ready held high.

Reset
REQ-031 rst=1 at a clock edge -> state IDLE, pc 0, issued_cnt 0, instr_valid 0, busy 0, done 0, err 0, start_ready 1 from the next cycle.
REQ-032 Reset mid-sequence discards the sequence without done or err.

Structure
REQ-033 Shared package nanorv32_parameter holds the state encoding, default UROM_ADDR_W/DATA_W, and the entry index constants (RESET, IRQ_ENTRY, IRQ_EXIT).
REQ-034 Sub-module nanorv32_useq_rom: combinational ROM, input addr, output DATA_W+1 word, contents between the micro_rom generation markers; default image: addr0..2 reset sequence (LAST at 2), addr8..11 irq entry (LAST at 11), addr16..17 irq exit (LAST at 17), addr24..31 no LAST.

Verification
REQ-035 Reset: start_entry=0, start_valid 1 cycle, instr_ready=1 -> words at addr 0,1,2 on 3 consecutive cycles, done one cycle later, issued_cnt=3.
REQ-036 Backpressure: entry 1, instr_ready toggled 1,0,0,1,1,1 -> instr_data held while ready=0, 4 words in order, done, issued_cnt=4.
REQ-037 Abort: entry 1, abort asserted on second handshake cycle -> IDLE next cycle, no done, issued_cnt=2.
REQ-038 Runaway: entry 3 -> 8 words addr 24..31, then IDLE with done and err pulsing together, issued_cnt=8.
REQ-039 Bad entry: NUM_ENTRY=3, start_entry=3 -> err pulse, busy stays 0, instr_valid stays 0.
REQ-040 Mid-reset: rst=1 during entry 1 after 2 words -> next cycle IDLE, outputs at reset values, no done.
